// File: rtl/ir_fetch_if.sv
// Bus bundle between the fetch sequencer, program memory and the instruction register.
// Latency: none (wires only).
// Backpressure: none; the sequencer ignores requests while busy.
interface ir_fetch_if #(
  parameter int ADDR_W = 8
);
  // Control from the sequencer's client
  logic              fetch_req;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;

  // Program memory port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;

  // Instruction register write port
  logic [7:0]        data_out;
  logic              load_upper;
  logic              load_lower;

  // Status
  logic              busy;
  logic              fetch_done;
  logic [ADDR_W-1:0] pc;

  // Sequencer side
  modport master (
    input  fetch_req, jump, jump_addr, mem_data,
    output mem_addr, mem_rd, data_out, load_upper, load_lower,
           busy, fetch_done, pc
  );

  // Client / memory / instruction register side
  modport slave (
    output fetch_req, jump, jump_addr, mem_data,
    input  mem_addr, mem_rd, data_out, load_upper, load_lower,
           busy, fetch_done, pc
  );
endinterface

// File: rtl/ir_fetch.sv
// Fetch sequencer: reads opcode then operand from byte-wide sync memory into the IR.
// Latency: fetch_done 4 cycles after fetch_req is sampled in IDLE; 5-cycle repeat rate.
// Backpressure: none; fetch_req/jump are sampled only in IDLE, ignored (not queued) when busy.
module ir_fetch #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     reset,
  ir_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_HI = 3'd1,
    S_LD_HI = 3'd2,
    S_LD_LO = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  // State and program counter registers; reset aborts any fetch immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state and pc: jump wins over fetch_req in IDLE; pc steps by 2 leaving LD_LO
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.jump) begin
          pc_d = bus.jump_addr;
        end else if (bus.fetch_req) begin
          state_d = S_RD_HI;
        end
      end
      S_RD_HI: state_d = S_LD_HI;
      S_LD_HI: state_d = S_LD_LO;
      S_LD_LO: begin
        state_d = S_DONE;
        pc_d    = pc_q + PC_STEP;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; LD_HI already issues the operand read so its data lands in LD_LO
  always_comb begin
    bus.mem_addr   = pc_q;
    bus.mem_rd     = 1'b0;
    bus.data_out   = 8'h00;
    bus.load_upper = 1'b0;
    bus.load_lower = 1'b0;
    bus.fetch_done = 1'b0;
    bus.busy       = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: ;
      S_RD_HI: begin
        bus.mem_rd = 1'b1;
      end
      S_LD_HI: begin
        bus.mem_addr   = pc_q + PC_ONE;
        bus.mem_rd     = 1'b1;
        bus.data_out   = bus.mem_data;
        bus.load_upper = 1'b1;
      end
      S_LD_LO: begin
        bus.data_out   = bus.mem_data;
        bus.load_lower = 1'b1;
      end
      S_DONE: begin
        bus.fetch_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pc = pc_q;

  // The instruction register must never see both halves written in one cycle
  a_one_load: assert property (@(posedge clk) disable iff (reset)
    !(bus.load_upper && bus.load_lower));

  // A completed fetch always returns to IDLE on the next edge
  a_done_idle: assert property (@(posedge clk) disable iff (reset)
    (state_q == S_DONE) |=> (state_q == S_IDLE));

endmodule

// File: tb/tb_ir_fetch.sv
// Self-checking bench for ir_fetch: fetch-offset model, synchronous memory, directed + random fetches.
// Latency: checks every cycle on the falling edge.
// Backpressure: n/a.
module tb_ir_fetch;

  localparam int          ADDR_W   = 8;
  localparam logic [7:0]  RESET_PC = 8'h00;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];

  ir_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  ir_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Byte-wide synchronous program memory: data appears the cycle after the read
  always @(posedge clk) begin
    if (bus.mem_rd === 1'b1) bus.mem_data <= mem[bus.mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: m_ph counts cycles since a fetch was accepted (0 = idle),
  // m_fpc is the pc the fetch started from.
  int         m_ph;
  logic [7:0] m_pc;
  logic [7:0] m_fpc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph <= 0;
      m_pc <= RESET_PC;
    end else if (m_ph == 0) begin
      if (bus.jump) m_pc <= bus.jump_addr;
      else if (bus.fetch_req) begin
        m_ph  <= 1;
        m_fpc <= m_pc;
      end
    end else begin
      if (m_ph == 3) m_pc <= m_fpc + 8'd2;
      m_ph <= (m_ph == 4) ? 0 : m_ph + 1;
    end
  end

  // Compare process plus instruction-register scoreboard
  int         n_done = 0;
  logic [7:0] sb_op, sb_opr;

  always @(negedge clk) begin
    logic [7:0] f1, e_do, e_addr;
    if (chk_en) begin
      f1     = m_fpc + 8'd1;
      e_do   = (m_ph == 2) ? mem[m_fpc] : (m_ph == 3) ? mem[f1] : 8'h00;
      e_addr = (m_ph == 2) ? f1 : m_pc;
      chk("busy",       32'(bus.busy),       32'(m_ph != 0));
      chk("mem_rd",     32'(bus.mem_rd),     32'(m_ph == 1 || m_ph == 2));
      chk("mem_addr",   32'(bus.mem_addr),   32'(e_addr));
      chk("load_upper", 32'(bus.load_upper), 32'(m_ph == 2));
      chk("load_lower", 32'(bus.load_lower), 32'(m_ph == 3));
      chk("fetch_done", 32'(bus.fetch_done), 32'(m_ph == 4));
      chk("data_out",   32'(bus.data_out),   32'(e_do));
      chk("pc",         32'(bus.pc),         32'(m_pc));
      chk("no_overlap", 32'(bus.load_upper && bus.load_lower), 32'd0);
      if (bus.load_upper === 1'b1) sb_op  = bus.data_out;
      if (bus.load_lower === 1'b1) sb_opr = bus.data_out;
      if (bus.fetch_done === 1'b1) begin
        n_done++;
        chk("sb_opcode",  32'(sb_op),  32'(mem[m_fpc]));
        chk("sb_operand", 32'(sb_opr), 32'(mem[f1]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int got;
    logic [31:0] done_mask;

    bus.fetch_req = 1'b0;
    bus.jump      = 1'b0;
    bus.jump_addr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    tick; tick;
    chk_en = 1'b1;
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_pc",       32'(bus.pc),       32'h00);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h00);
    chk("rst_mem_rd",   32'(bus.mem_rd),   32'd0);
    chk("rst_data_out", 32'(bus.data_out), 32'h00);
    reset = 1'b0;
    tick;

    // Single fetch from pc=0
    mem[0] = 8'hA5; mem[1] = 8'h3C;
    bus.fetch_req = 1'b1;
    tick; bus.fetch_req = 1'b0;
    chk("t1_c1_mem_rd", 32'(bus.mem_rd), 32'd1);
    tick;
    chk("t1_c2_load_upper", 32'(bus.load_upper), 32'd1);
    chk("t1_c2_data",       32'(bus.data_out),   32'hA5);
    chk("t1_c2_mem_addr",   32'(bus.mem_addr),   32'h01);
    tick;
    chk("t1_c3_load_lower", 32'(bus.load_lower), 32'd1);
    chk("t1_c3_data",       32'(bus.data_out),   32'h3C);
    tick;
    chk("t1_c4_done", 32'(bus.fetch_done), 32'd1);
    chk("t1_c4_pc",   32'(bus.pc),         32'h02);
    tick;
    chk("t1_c5_idle", 32'(bus.busy), 32'd0);

    // Back-to-back fetches with fetch_req held
    bus.jump = 1'b1; bus.jump_addr = 8'h00;
    tick; bus.jump = 1'b0;
    chk("t2_jump_pc", 32'(bus.pc), 32'h00);
    bus.fetch_req = 1'b1;
    done_mask = '0;
    for (int i = 1; i <= 15; i++) begin
      tick;
      if (bus.fetch_done === 1'b1) done_mask[i] = 1'b1;
    end
    bus.fetch_req = 1'b0;
    chk("t2_done_cycles", done_mask, 32'h0000_4210);
    chk("t2_final_pc",    32'(bus.pc), 32'h06);
    tick;

    // Jump to FF then fetch across the wrap
    mem[8'hFF] = 8'h11; mem[8'h00] = 8'h22;
    bus.jump = 1'b1; bus.jump_addr = 8'hFF;
    tick; bus.jump = 1'b0;
    chk("t3_jump_pc", 32'(bus.pc), 32'hFF);
    bus.fetch_req = 1'b1;
    tick; bus.fetch_req = 1'b0;
    tick;
    chk("t3_opcode", 32'(bus.data_out), 32'h11);
    tick;
    chk("t3_operand", 32'(bus.data_out), 32'h22);
    tick;
    chk("t3_pc", 32'(bus.pc), 32'h01);
    tick;

    // Jump and fetch_req together: jump wins
    bus.jump = 1'b1; bus.fetch_req = 1'b1; bus.jump_addr = 8'h40;
    tick; bus.jump = 1'b0; bus.fetch_req = 1'b0;
    chk("t4_pc_jump", 32'(bus.pc),   32'h40);
    chk("t4_busy",    32'(bus.busy), 32'd0);
    tick;
    chk("t4_busy2",   32'(bus.busy), 32'd0);
    // Jump during LD_HI is ignored
    bus.fetch_req = 1'b1;
    tick; bus.fetch_req = 1'b0;
    tick;
    bus.jump = 1'b1; bus.jump_addr = 8'h10;
    tick; bus.jump = 1'b0;
    tick;
    chk("t4_pc_after", 32'(bus.pc), 32'h42);
    tick;

    // Reset asserted mid LD_LO
    snap = n_done;
    bus.fetch_req = 1'b1;
    tick; bus.fetch_req = 1'b0;
    tick; tick;
    chk("t5_in_ld_lo", 32'(bus.load_lower), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_load_lower", 32'(bus.load_lower), 32'd0);
    chk("t5_busy",       32'(bus.busy),       32'd0);
    chk("t5_pc",         32'(bus.pc),         32'(RESET_PC));
    tick; tick;
    reset = 1'b0;
    tick; tick; tick;
    chk("t5_no_done", 32'(n_done), 32'(snap));

    // Random memory, 200 fetches with occasional jumps
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    snap = n_done;
    for (int f = 0; f < 200; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.jump      = 1'b1;
        bus.jump_addr = 8'($urandom_range(0, 255));
        bus.fetch_req = 1'($urandom_range(0, 1));
        tick;
        bus.jump = 1'b0; bus.fetch_req = 1'b0;
      end
      bus.fetch_req = 1'b1;
      tick; bus.fetch_req = 1'b0;
      got = 0;
      for (int w = 0; w < 8 && got == 0; w++) begin
        tick;
        if (bus.fetch_done === 1'b1) got = 1;
      end
      if (got == 0) chk("rnd_fetch_timeout", 32'(got), 32'd1);
      tick;
    end
    chk("rnd_done_count", 32'(n_done - snap), 32'd200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
